// File: rtl/uart_ctrl_pkg.sv
// Shared types and constants for the UART transmit arbiter slice.
// Holds the arbiter FSM state encoding, the UART byte width and default timeouts.
package uart_ctrl_pkg;

  localparam int UART_DATA_W           = 8;
  localparam int DEF_NUM_REQ           = 4;
  localparam int DEF_START_TIMEOUT     = 16;
  localparam int DEF_FRAME_TIMEOUT     = 2048;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD      = 3'd1,
    START     = 3'd2,
    WAIT_BUSY = 3'd3,
    WAIT_DONE = 3'd4,
    DONE      = 3'd5
  } arb_state_e;

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: first asserted request scanning upward from rr_ptr,
// wrapping modulo NUM_REQ.
module uart_rr_pick #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] rr_ptr,
  output logic [$clog2(NUM_REQ)-1:0] winner,
  output logic                       any_req
);

  localparam int PTR_W = $clog2(NUM_REQ);

  int idx;

  // Scan offsets from the highest down so the smallest offset from rr_ptr wins last.
  always_comb begin
    winner  = '0;
    any_req = 1'b0;
    idx     = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (req[idx]) begin
        winner  = PTR_W'(idx);
        any_req = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NUM_REQ byte requesters.
// Sequences write_tx/ready_tx, tracks tx_busy, acknowledges the winner and flags hung frames.
module uart_tx_arbiter
  import uart_ctrl_pkg::*;
#(
  parameter int NUM_REQ       = DEF_NUM_REQ,
  parameter int START_TIMEOUT = DEF_START_TIMEOUT,
  parameter int FRAME_TIMEOUT = DEF_FRAME_TIMEOUT
) (
  input  logic                           clk_tx,
  input  logic                           rst_tx,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [UART_DATA_W*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]             ack,
  output logic [$clog2(NUM_REQ)-1:0]     grant_id,
  output logic                           grant_valid,
  output logic [UART_DATA_W-1:0]         data_tx,
  output logic                           write_tx,
  output logic                           ready_tx,
  input  logic                           tx_busy,
  output logic                           timeout_err
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int TMR_W = $clog2(FRAME_TIMEOUT) + 1;
  localparam logic [TMR_W-1:0] START_LIMIT = TMR_W'(START_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] FRAME_LIMIT = TMR_W'(FRAME_TIMEOUT - 1);
  localparam logic [PTR_W-1:0] LAST_IDX    = PTR_W'(NUM_REQ - 1);

  arb_state_e             state;
  arb_state_e             state_next;
  logic [PTR_W-1:0]       rr_ptr;
  logic [PTR_W-1:0]       winner;
  logic                   any_req;
  logic [TMR_W-1:0]       timer;
  logic                   timer_clear;
  logic                   set_timeout;
  logic                   timed_out;
  logic [UART_DATA_W-1:0] data_q;

  uart_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req     (req),
    .rr_ptr  (rr_ptr),
    .winner  (winner),
    .any_req (any_req)
  );

  // Next-state logic; tx_busy is only looked at once the FSM has left START.
  always_comb begin
    state_next  = state;
    timer_clear = 1'b0;
    set_timeout = 1'b0;
    case (state)
      IDLE:      if (any_req) state_next = LOAD;
      LOAD:      state_next = START;
      START: begin
        state_next  = WAIT_BUSY;
        timer_clear = 1'b1;
      end
      WAIT_BUSY: begin
        if (tx_busy) begin
          state_next  = WAIT_DONE;
          timer_clear = 1'b1;
        end else if (timer == START_LIMIT) begin
          state_next  = DONE;
          set_timeout = 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          state_next = DONE;
        end else if (timer == FRAME_LIMIT) begin
          state_next  = DONE;
          set_timeout = 1'b1;
        end
      end
      DONE:      state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // The byte is captured on the grant edge so it is already on data_tx while write_tx is high.
  always_ff @(posedge clk_tx) begin
    if (rst_tx) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      timer     <= '0;
      grant_id  <= '0;
      data_q    <= '0;
      timed_out <= 1'b0;
    end else begin
      state     <= state_next;
      timed_out <= set_timeout;
      if (timer_clear) begin
        timer <= '0;
      end else if (timer != '1) begin
        timer <= timer + TMR_W'(1);
      end
      if (state == IDLE && any_req) begin
        grant_id <= winner;
        data_q   <= req_data[int'(winner)*UART_DATA_W +: UART_DATA_W];
      end
      if (state == DONE) begin
        rr_ptr <= (grant_id == LAST_IDX) ? '0 : grant_id + PTR_W'(1);
      end
    end
  end

  always_comb begin
    ack = '0;
    if (state == DONE) ack[grant_id] = 1'b1;
  end

  assign write_tx    = (state == LOAD);
  assign ready_tx    = (state == START);
  assign grant_valid = (state == LOAD) || (state == START) || (state == WAIT_BUSY) ||
                       (state == WAIT_DONE) || (state == DONE);
  assign timeout_err = timed_out;
  assign data_tx     = data_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized bench for uart_tx_arbiter: acts as requesters and transmitter, predicting
// grant order, frame timing and timeouts from a simple round-robin model.
module tb_uart_tx_arbiter;
  import uart_ctrl_pkg::*;

  localparam int NUM_REQ  = 4;
  localparam int START_TO = 16;
  localparam int FRAME_TO = 2048;

  logic                clk_tx = 1'b0;
  logic                rst_tx = 1'b1;
  logic [NUM_REQ-1:0]  req = '0;
  logic [8*NUM_REQ-1:0] req_data = '0;
  logic [NUM_REQ-1:0]  ack;
  logic [1:0]          grant_id;
  logic                grant_valid;
  logic [7:0]          data_tx;
  logic                write_tx;
  logic                ready_tx;
  logic                tx_busy = 1'b0;
  logic                timeout_err;

  int checks = 0;
  int errors = 0;
  int modelPtr = 0;
  int lastGrant = -1;
  bit tight = 1'b0;
  logic [NUM_REQ-1:0] reReq = '0;
  logic [NUM_REQ-1:0] midReq = '0;
  logic [7:0] reqByte [NUM_REQ];

  uart_tx_arbiter #(
    .NUM_REQ(NUM_REQ), .START_TIMEOUT(START_TO), .FRAME_TIMEOUT(FRAME_TO)
  ) dut (
    .clk_tx(clk_tx), .rst_tx(rst_tx), .req(req), .req_data(req_data),
    .ack(ack), .grant_id(grant_id), .grant_valid(grant_valid), .data_tx(data_tx),
    .write_tx(write_tx), .ready_tx(ready_tx), .tx_busy(tx_busy), .timeout_err(timeout_err)
  );

  always #5 clk_tx = ~clk_tx;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Round-robin rule: first pending requester at or after the pointer, wrapping.
  function automatic int modelWinner(input logic [NUM_REQ-1:0] r, input int ptr);
    for (int k = 0; k < NUM_REQ; k++) begin
      if (r[(ptr + k) % NUM_REQ]) return (ptr + k) % NUM_REQ;
    end
    return -1;
  endfunction

  task automatic raiseReq(input int i, input logic [7:0] b);
    if (!req[i]) begin
      reqByte[i]       = b;
      req_data[i*8 +: 8] = b;
      req[i]           = 1'b1;
    end
  endtask

  task automatic applyReset();
    @(negedge clk_tx);
    rst_tx  = 1'b1;
    req     = '0;
    tx_busy = 1'b0;
    @(negedge clk_tx);
    checkOutput("reset_outputs",
                {ack, grant_id, grant_valid, data_tx, write_tx, ready_tx, timeout_err}, 0);
    @(negedge clk_tx);
    rst_tx   = 1'b0;
    modelPtr = 0;
    tight    = 1'b0;
  endtask

  // One complete frame. mode 0: busy rises a cycles after ready_tx for len cycles;
  // mode 1: busy never rises; mode 2: busy rises and sticks.
  task automatic applyStimulus(input int mode, input int a, input int len);
    int w, waitCnt, expOff;
    bit seen;
    w = modelWinner(req, modelPtr);
    seen = 1'b0;
    waitCnt = 0;
    while (!seen && waitCnt < 40) begin
      @(negedge clk_tx);
      if (write_tx) seen = 1'b1;
      else waitCnt++;
    end
    checkOutput("write_tx_seen", 32'(seen), 1);
    if (!seen || w < 0) return;
    if (tight) checkOutput("ack_to_write_gap", waitCnt, 0);
    lastGrant = w;
    checkOutput("grant_id", grant_id, w);
    checkOutput("data_tx", data_tx, reqByte[w]);
    checkOutput("load_valid_ready", {grant_valid, ready_tx}, 2'b10);
    @(negedge clk_tx);
    checkOutput("ready_tx", {write_tx, ready_tx}, 2'b01);
    checkOutput("data_hold", data_tx, reqByte[w]);
    expOff = (mode == 0) ? a + len + 1 : (mode == 1) ? START_TO + 1 : a + 1 + FRAME_TO;
    for (int n = 1; n <= expOff; n++) begin
      @(negedge clk_tx);
      if (n < expOff) begin
        checkOutput("in_frame_outputs",
                    {ack, timeout_err, grant_valid, grant_id, write_tx, ready_tx},
                    {4'b0, 1'b0, 1'b1, 2'(w), 2'b00});
        if (n == 1) begin
          for (int i = 0; i < NUM_REQ; i++)
            if (midReq[i]) raiseReq(i, 8'($urandom));
        end
        if (mode != 1 && n == a) tx_busy = 1'b1;
        if (mode == 0 && n == a + len) tx_busy = 1'b0;
      end else begin
        checkOutput("ack", ack, 32'(1 << w));
        checkOutput("timeout_err", timeout_err, 32'(mode != 0));
        checkOutput("grant_valid_done", {grant_valid, grant_id}, {1'b1, 2'(w)});
        tx_busy = 1'b0;
        req[w]  = 1'b0;
        if (reReq[w]) raiseReq(w, 8'($urandom));
        modelPtr = (w + 1) % NUM_REQ;
      end
    end
    tight = (req != 0);
    @(negedge clk_tx);
    checkOutput("idle_after_done", {grant_valid, write_tx, ack, timeout_err}, 0);
  endtask

  task automatic drain();
    reReq  = '0;
    midReq = '0;
    while (req != 0) applyStimulus(0, $urandom_range(1, 5), $urandom_range(1, 12));
  endtask

  initial begin
    bit seen;
    applyReset();

    // Single request with a long frame.
    raiseReq(1, 8'h4D);
    applyStimulus(0, 1, 100);
    checkOutput("single_grant", lastGrant, 1);

    // All four requesting continuously from a fresh pointer.
    applyReset();
    for (int i = 0; i < NUM_REQ; i++) raiseReq(i, 8'($urandom));
    reReq = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, $urandom_range(1, 4), $urandom_range(1, 10));
      checkOutput("rr_order", lastGrant, i % NUM_REQ);
    end
    drain();

    // Requester 2 arriving mid-frame must be served before requester 0 again.
    raiseReq(0, 8'($urandom));
    reReq  = 4'b0001;
    midReq = 4'b0100;
    applyStimulus(0, 2, 8);
    checkOutput("fair_first", lastGrant, 0);
    midReq = '0;
    applyStimulus(0, 2, 8);
    checkOutput("fair_second", lastGrant, 2);
    drain();

    // Start timeout, then frame timeout followed by a normal frame.
    raiseReq($urandom_range(0, 3), 8'($urandom));
    applyStimulus(1, 0, 0);
    raiseReq($urandom_range(0, 3), 8'($urandom));
    applyStimulus(2, 1, 0);
    raiseReq($urandom_range(0, 3), 8'($urandom));
    applyStimulus(0, 3, 5);

    // Random traffic.
    for (int f = 0; f < 30; f++) begin
      for (int i = 0; i < NUM_REQ; i++)
        if ($urandom_range(0, 2) == 0) raiseReq(i, 8'($urandom));
      if (req == 0) raiseReq($urandom_range(0, 3), 8'($urandom));
      reReq  = 4'($urandom);
      midReq = 4'($urandom);
      applyStimulus(($urandom_range(0, 9) == 0) ? 1 : 0,
                    $urandom_range(1, 6), $urandom_range(1, 20));
    end
    drain();

    // Reset while a frame is in WAIT_DONE.
    raiseReq(2, 8'($urandom));
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk_tx);
      if (write_tx) seen = 1'b1;
    end
    checkOutput("reset_test_write", 32'(seen), 1);
    @(negedge clk_tx);
    tx_busy = 1'b1;
    repeat (4) @(negedge clk_tx);
    checkOutput("pre_reset_busy", {grant_valid, ack}, {1'b1, 4'b0});
    applyReset();
    repeat (2) @(negedge clk_tx);
    checkOutput("no_ack_after_reset", {ack, grant_valid}, 0);
    raiseReq(3, 8'($urandom));
    applyStimulus(0, 2, 6);
    checkOutput("post_reset_grant", lastGrant, 3);
    raiseReq(1, 8'($urandom));
    raiseReq(2, 8'($urandom));
    applyStimulus(0, 1, 3);
    checkOutput("post_reset_next", lastGrant, 1);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
